seg_scan_mux: RTL and testbench

//  Time-multiplexed scan driver for an N-digit common-anode 7-segment bank.

---
 rtl/seg_pkg.sv | 6 +
 rtl/seg_scan_mux.sv | 114 +++++++++++
 tb/tb_seg_scan_mux.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver family.
package seg_pkg;
  localparam int unsigned SEG_DIGITS_MAX = 8;
  localparam logic [SEG_DIGITS_MAX-1:0] ANODE_OFF = '1;
  typedef logic [3:0] nibble_t;
endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for a common-anode 7-segment bank with
// double-buffered value, per-slot dead time, digit mask and leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     en_mask,
  input  logic                    lz_blank,
  output logic [3:0]              bin,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     pnp,
  output logic                    frame_done
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned VAL_W = 4 * N_DIGITS;

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [VAL_W-1:0]    shadow_val;
  logic [N_DIGITS-1:0] shadow_dp;
  logic [VAL_W-1:0]    active_val;
  logic [N_DIGITS-1:0] active_dp;

  logic                slot_end_c;
  logic                frame_end_c;
  nibble_t             nib_c;
  logic                dp_c;
  logic                en_c;
  logic                blank_c;
  logic                show_c;
  logic [N_DIGITS-1:0] sel_c;

  // Current-digit selection and leading-zero blank evaluation
  always_comb begin
    slot_end_c  = (pre == PRE_W'(REFRESH_DIV - 1));
    frame_end_c = slot_end_c && (idx == IDX_W'(N_DIGITS - 1));
    nib_c       = 4'h0;
    dp_c        = 1'b0;
    en_c        = 1'b0;
    sel_c       = '0;
    blank_c     = lz_blank && (idx != '0);
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (IDX_W'(i) == idx) begin
        nib_c    = active_val[4*i +: 4];
        dp_c     = active_dp[i];
        en_c     = en_mask[i];
        sel_c[i] = 1'b1;
      end
      // Any nonzero nibble at or above the current digit keeps it visible
      if ((IDX_W'(i) >= idx) && (active_val[4*i +: 4] != 4'h0)) begin
        blank_c = 1'b0;
      end
    end
    show_c = (pre >= PRE_W'(DEAD_CYCLES)) && en_c && !blank_c;
  end

  // Prescaler and digit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      pre <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Shadow capture on load; active copy only at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (frame_end_c) begin
        active_val <= load ? value : shadow_val;
        active_dp  <= load ? dp_in : shadow_dp;
      end
    end
  end

  // Registered outputs, one cycle behind the state they reflect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pnp        <= ANODE_OFF[N_DIGITS-1:0];
      bin        <= 4'h0;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      pnp        <= show_c ? ~sel_c : ANODE_OFF[N_DIGITS-1:0];
      bin        <= nib_c;
      dp_n       <= show_c ? ~dp_c : 1'b1;
      frame_done <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus pushes expected outputs from a
// time-based reference model, a monitor pops and compares after every edge.
module tb_seg_scan_mux;

  localparam int N    = 4;
  localparam int RD   = 8;
  localparam int DEAD = 2;
  localparam int NR   = N * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  en_mask = 4'hF;
  logic        lz_blank = 1'b0;
  logic [3:0]  bin;
  logic        dp_n;
  logic [3:0]  pnp;
  logic        frame_done;

  seg_scan_mux #(.N_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .en_mask(en_mask), .lz_blank(lz_blank), .bin(bin), .dp_n(dp_n),
    .pnp(pnp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pnp;
    logic [3:0] bin;
    logic       dp_n;
    logic       fd;
    int         c;
  } exp_t;

  typedef struct {
    int          f;
    logic [15:0] v;
    logic [3:0]  dp;
  } ld_t;

  exp_t exp_q[$];
  ld_t  loads[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  logic [3:0] en_cur = 4'hF;
  logic       lz_cur = 1'b0;

  task automatic chk(input string name, input int act, input int req, input int c);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
  endtask

  // Value shown in frame f: the last load made before that frame began
  function automatic void frame_disp(input int f, output logic [15:0] v, output logic [3:0] dp);
    v = 16'h0;
    dp = 4'h0;
    for (int k = loads.size() - 1; k >= 0; k--) begin
      if (loads[k].f <= f) begin
        v  = loads[k].v;
        dp = loads[k].dp;
        break;
      end
    end
  endfunction

  function automatic exp_t model(input int c, input logic [3:0] en, input logic lz);
    exp_t        e;
    logic [15:0] v;
    logic [15:0] upper;
    logic [3:0]  dp;
    logic [3:0]  one;
    int          pre, d, f;
    logic        blank, show;
    pre   = c % RD;
    d     = (c / RD) % N;
    f     = c / NR;
    frame_disp(f, v, dp);
    upper = v >> (4 * d);
    blank = lz && (d != 0) && (upper == 16'h0);
    show  = (pre >= DEAD) && en[d] && !blank;
    one   = 4'b0001;
    e.pnp  = show ? ~(one << d) : 4'hF;
    e.bin  = upper[3:0];
    e.dp_n = show ? ~dp[d] : 1'b1;
    e.fd   = (d == N - 1) && (pre == RD - 1);
    e.c    = c;
    return e;
  endfunction

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp);
    @(negedge clk);
    load     = ld;
    value    = v;
    dp_in    = dp;
    en_mask  = en_cur;
    lz_blank = lz_cur;
    exp_q.push_back(model(cyc, en_cur, lz_cur));
    if (ld) loads.push_back('{cyc / NR + 1, v, dp});
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) idle(1);
  endtask

  // Assert reset between edges and check outputs clear without a clock
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst  = 1'b1;
    load = 1'b0;
    #1;
    chk("rst_pnp", int'(pnp), 4'hF, cyc);
    chk("rst_bin", int'(bin), 0, cyc);
    chk("rst_dp_n", int'(dp_n), 1, cyc);
    chk("rst_frame_done", int'(frame_done), 0, cyc);
    @(posedge clk);
    #2;
    exp_q.delete();
    loads.delete();
    cyc = 0;
    rst = 1'b0;
  endtask

  // Monitor: compare after each rising edge whenever an expectation is pending
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pnp", int'(pnp), int'(e.pnp), e.c);
        chk("bin", int'(bin), int'(e.bin), e.c);
        chk("dp_n", int'(dp_n), int'(e.dp_n), e.c);
        chk("frame_done", int'(frame_done), int'(e.fd), e.c);
      end
    end
  end

  initial begin
    // Reset mid-slot while digit 0 is lit
    do_reset();
    idle(5);
    @(posedge clk);
    #3;
    chk("pre_rst_pnp", int'(pnp), 4'hE, cyc);
    do_reset();
    idle(NR + 3);

    // Basic scan, then mid-frame load and a load on the boundary cycle
    do_reset();
    step(1'b1, 16'h1234, 4'h0);
    idle_until(42);
    step(1'b1, 16'hABCD, 4'h0);
    idle_until(3 * NR - 1);
    step(1'b1, 16'h5A0F, 4'h0);
    idle_until(4 * NR + 8);

    // Leading-zero blanking
    do_reset();
    lz_cur = 1'b1;
    step(1'b1, 16'h0050, 4'h0);
    idle(2 * NR);
    step(1'b1, 16'h0000, 4'h0);
    idle(2 * NR);
    lz_cur = 1'b0;

    // Digit mask and decimal points
    do_reset();
    en_cur = 4'b1010;
    step(1'b1, 16'h1234, 4'b0010);
    idle(2 * NR + 4);
    en_cur = 4'hF;

    // Back-to-back loads in one frame
    do_reset();
    idle(3);
    step(1'b1, 16'h1111, 4'h1);
    step(1'b1, 16'h2222, 4'h4);
    idle(2 * NR);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 40) == 0) en_cur = 4'($urandom);
      if ($urandom_range(0, 60) == 0) lz_cur = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        logic [15:0] rv;
        rv = 16'($urandom);
        if ($urandom_range(0, 2) == 0) rv = rv & 16'h00FF;
        step(1'b1, rv, 4'($urandom));
      end else begin
        idle(1);
      end
    end

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
